// File: rtl/resp_stream_checker_if.sv
// Response/expected-stream bundle for resp_stream_checker: sampled DUT output
// plus the golden expected stream with its valid/ready handshake.
interface resp_stream_checker_if #(
  parameter int unsigned WIDTH = 199
);
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_valid;
  logic             exp_ready;

  modport master (
    output y, y_valid, exp_data, exp_valid,
    input  exp_ready
  );

  modport slave (
    input  y, y_valid, exp_data, exp_valid,
    output exp_ready
  );
endinterface

// File: rtl/resp_stream_checker.sv
// Buffers DUT response samples in a small FIFO and compares them in order
// against a golden stream. Optional MISR signature under RESP_MISR_SIG_EN.
module resp_stream_checker #(
  parameter int unsigned WIDTH       = 199,
  parameter int unsigned NUM_VECTORS = 21,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  resp_stream_checker_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  overflow,
  output logic [CNT_W-1:0]      mismatch_cnt,
  output logic [CNT_W-1:0]      cmp_idx,
  output logic [CNT_W-1:0]      first_err_idx,
  output logic [WIDTH-1:0]      first_err_diff,
  output logic [31:0]           signature
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic [CNT_W-1:0] r_cmp_idx;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_diff;

  logic             w_full;
  logic             w_empty;
  logic             w_ready;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_last;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_diff;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_ready = (r_state == RUN) && !w_empty;
  assign w_pop   = w_ready && bus.exp_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = (r_state == RUN) && bus.y_valid && (!w_full || w_pop);
  assign w_drop  = (r_state == RUN) && bus.y_valid && w_full && !w_pop;
  assign w_diff  = w_head ^ bus.exp_data;
  assign w_last  = (r_cmp_idx == CNT_W'(NUM_VECTORS - 1));

  assign bus.exp_ready = w_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_overflow       <= 1'b0;
      r_mismatch_cnt   <= '0;
      r_cmp_idx        <= '0;
      r_first_err_idx  <= '0;
      r_first_err_diff <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state          <= RUN;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_overflow       <= 1'b0;
            r_mismatch_cnt   <= '0;
            r_cmp_idx        <= '0;
            r_first_err_idx  <= '0;
            r_first_err_diff <= '0;
          end
        end
        RUN: begin
          if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
          if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
          unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
          endcase
          if (w_drop) r_overflow <= 1'b1;
          if (w_pop) begin
            r_cmp_idx <= r_cmp_idx + CNT_W'(1);
            if (|w_diff) begin
              if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
              // Count never wraps back to zero, so zero marks the first failure.
              if (r_mismatch_cnt == '0) begin
                r_first_err_idx  <= r_cmp_idx;
                r_first_err_diff <= w_diff;
              end
            end
            if (w_last) r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RESP_MISR_SIG_EN
  localparam int unsigned NSLICE = (WIDTH + 31) / 32;

  logic [31:0]          r_sig;
  logic [NSLICE*32-1:0] w_pad;
  logic [31:0]          w_fold;

  always_comb begin
    w_pad             = '0;
    w_pad[WIDTH-1:0]  = w_head;
    w_fold            = '0;
    for (int unsigned i = 0; i < NSLICE; i++) w_fold = w_fold ^ w_pad[i*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= '0;
    end else if ((r_state != RUN) && start) begin
      r_sig <= '0;
    end else if (w_pop) begin
      r_sig <= {r_sig[30:0], r_sig[31] ^ r_sig[21] ^ r_sig[1] ^ r_sig[0]} ^ w_fold;
    end
  end

  assign signature = r_sig;
`else
  assign signature = '0;
`endif

  assign busy           = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign pass           = done && (r_mismatch_cnt == '0) && !r_overflow;
  assign overflow       = r_overflow;
  assign mismatch_cnt   = r_mismatch_cnt;
  assign cmp_idx        = r_cmp_idx;
  assign first_err_idx  = r_first_err_idx;
  assign first_err_diff = r_first_err_diff;
endmodule

// File: doc/resp_stream_checker.md
Name: resp_stream_checker

Overview:
- Response-side counterpart to the stimulus driver in the fuzz simulation flow.
- Samples the 199-bit synthesized-DUT output `y` on each valid clock and buffers it in a small FIFO.
- Compares each buffered sample in order against a golden expected stream delivered over a valid/ready handshake.
- Reports mismatch count, first-failure info, overflow, pass/done and an optional 32-bit MISR signature of the response stream.

Parameters:
- WIDTH, 199, width of DUT output sample and expected data.
- NUM_VECTORS, 21, number of compares per run before DONE.
- FIFO_DEPTH, 4, response buffer depth (power of 2, >=2).
- CNT_W, 16, width of counters and index outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin/restart a run (pulse).
- y  input  WIDTH  DUT response sample.
- y_valid  input  1  y is valid this cycle.
- exp_data  input  WIDTH  golden expected sample.
- exp_valid  input  1  exp_data valid.
- exp_ready  output  1  checker accepts exp_data this cycle.
- busy  output  1  state == RUN.
- done  output  1  run complete (held).
- pass  output  1  valid when done; 1 = no mismatch and no overflow.
- overflow  output  1  sticky; a sample was dropped on a full FIFO.
- mismatch_cnt  output  CNT_W  saturating mismatch count.
- cmp_idx  output  CNT_W  number of compares completed.
- first_err_idx  output  CNT_W  index of first mismatching compare.
- first_err_diff  output  WIDTH  y XOR exp_data of first mismatch.
- signature  output  32  MISR signature (0 without feature).

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-run):
  - Next state IDLE; FIFO empty.
  - All outputs 0; exp_ready=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN. Clears counters, FIFO, overflow, first_err_*, signature.
  - RUN: start ignored. Go to DONE on the edge where cmp_idx becomes NUM_VECTORS.
  - DONE: outputs held. start=1 -> RUN with the same clears as IDLE.
- Push (RUN only): y_valid=1 and FIFO not full -> write y.
  - y_valid in IDLE/DONE is ignored.
  - Full and no pop in the same cycle -> sample dropped, overflow<=1 (sticky).
  - Full with a simultaneous pop -> push accepted.
- exp_ready = (state==RUN) && FIFO not empty. Combinational from registered state and FIFO count.
- Compare on exp_valid && exp_ready:
  - Pop head, head vs exp_data, cmp_idx++.
  - Mismatch = any bit differs. mismatch_cnt++, saturating at all-ones.
  - On the first mismatch only: first_err_idx <= pre-increment cmp_idx, first_err_diff <= head ^ exp_data.
- Latency:
  - Compare results are registered and visible 1 cycle after the handshake.
  - done=1 and pass are valid on that same cycle for the final compare.
  - pass = (mismatch_cnt_final==0) && !overflow.
- Empty FIFO with push in the same cycle: no bypass. The sample becomes comparable the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro RESP_MISR_SIG_EN.
- Defined:
  - On each compare pop: signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold(head).
  - fold = XOR of 32-bit slices of head, zero-padded to a multiple of 32.
  - Cleared on reset/start.
- Undefined: signature constant 0; no MISR logic synthesized.

Test Plan:
- Reset then start; push 21 samples y=i, exp_data=i, exp_valid always 1 -> done=1, pass=1, mismatch_cnt=0, cmp_idx=21, overflow=0.
- Exp sample 5 = 5^199'h4 (bit 2 flipped), sample 9 also differs -> mismatch_cnt=2, first_err_idx=5, first_err_diff=199'h4, pass=0.
- exp_valid=0 for 6 cycles while y_valid=1 -> 4 samples buffered, 2 dropped, overflow=1. At end, pass=0 even with all compares matching.
- FIFO full, y_valid=1 and handshake in the same cycle -> no drop, overflow stays 0, count stays 4.
- Assert rst for 1 cycle after 10 compares -> next cycle IDLE, all outputs 0, exp_ready=0. A subsequent start runs 21 fresh compares.
- With RESP_MISR_SIG_EN: single compare head=199'h1 from signature 0 -> signature=32'h1. Without the macro -> signature=0 throughout.
